// File: rtl/pe_row_pkg.sv
// pe_row_pkg: shared widths and beat/result record types for the PE row feeder.
package pe_row_pkg;
   localparam int P_DW = 16;
   localparam int P_AW = 32;
   localparam int LW   = 16;
   typedef struct packed {
      logic [P_DW-1:0] a0;
      logic [P_DW-1:0] a1;
      logic [P_DW-1:0] b;
      logic            last;
   } beat_t;
   typedef struct packed {
      logic [P_AW-1:0] c0;
      logic [P_AW-1:0] c1;
      logic [LW-1:0]   len;
   } res_t;
endpackage

// File: rtl/pe_row_sync_fifo.sv
// pe_row_sync_fifo: small synchronous FIFO with occupancy count; writes while full are dropped.
module pe_row_sync_fifo #(
   parameter int W = 8,
   parameter int D = 4,
   localparam int PW = (D > 1) ? $clog2(D) : 1,
   localparam int CW = $clog2(D + 1)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   input  logic [W-1:0]  i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [W-1:0]  o_data,
   output logic [CW-1:0] o_count
);
   logic [W-1:0]  r_mem [D];
   logic [PW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_count;
   logic          w_push, w_pop;
   assign w_push  = i_valid && (32'(r_count) != D);
   assign w_pop   = o_valid && i_ready;
   assign o_valid = r_count != '0;
   assign o_data  = r_mem[r_rd];
   assign o_count = r_count;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < D; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= (32'(r_wr) == D - 1) ? '0 : r_wr + 1'b1;
         end
         if (w_pop) r_rd <= (32'(r_rd) == D - 1) ? '0 : r_rd + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/pe_row_feeder.sv
// pe_row_feeder: buffers operand beats into the 1x2 PE row with a1 skewed one cycle,
// and turns the never-cleared PE accumulators into per-tile dot products.
module pe_row_feeder import pe_row_pkg::*; #(
   parameter int DW         = P_DW,
   parameter int AW         = P_AW,
   parameter int FIFO_DEPTH = 4,
   parameter int RES_DEPTH  = 2
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   input  logic [DW-1:0] i_in_a0,
   input  logic [DW-1:0] i_in_a1,
   input  logic [DW-1:0] i_in_b,
   input  logic          i_in_last,
   output logic [DW-1:0] o_a0,
   output logic [DW-1:0] o_a1,
   output logic [DW-1:0] o_b0,
   input  logic [AW-1:0] i_pe_c0,
   input  logic [AW-1:0] i_pe_c1,
   output logic          o_res_valid,
   input  logic          i_res_ready,
   output logic [AW-1:0] o_res_c0,
   output logic [AW-1:0] o_res_c1,
   output logic [LW-1:0] o_res_len
);
   beat_t                            w_in_beat, w_head;
   res_t                             w_res_in, w_res_out;
   logic                             w_head_valid, w_stall, w_issue;
   logic [$clog2(FIFO_DEPTH+1)-1:0]  w_in_count;
   logic [$clog2(RES_DEPTH+1)-1:0]   w_res_count;
   logic [DW-1:0]                    r_a1;
   logic                             r_last1, r_last2;
   logic [LW-1:0]                    r_cnt, r_len1, r_len2;
   logic [AW-1:0]                    r_cap0, r_prev0, r_prev1;

   assign o_in_ready = !rst && (32'(w_in_count) != FIFO_DEPTH);
   assign w_in_beat  = '{a0: i_in_a0, a1: i_in_a1, b: i_in_b, last: i_in_last};

   pe_row_sync_fifo #(.W($bits(beat_t)), .D(FIFO_DEPTH)) u_in_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_in_valid && o_in_ready),
      .i_data  (w_in_beat),
      .o_valid (w_head_valid),
      .i_ready (!w_stall),
      .o_data  (w_head),
      .o_count (w_in_count)
   );

   // Reserve buffer space for every tile still in the c0/c1 pipe so pushes never overflow.
   assign w_stall = 32'(w_res_count) + 32'(r_last1) + 32'(r_last2) >= 32'(RES_DEPTH);
   assign w_issue = w_head_valid && !w_stall;
   assign o_a0    = w_issue ? w_head.a0 : '0;
   assign o_b0    = w_issue ? w_head.b : '0;
   assign o_a1    = r_a1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a1    <= '0;
         r_last1 <= 1'b0;
         r_last2 <= 1'b0;
         r_cnt   <= '0;
         r_len1  <= '0;
         r_len2  <= '0;
         r_cap0  <= '0;
         r_prev0 <= '0;
         r_prev1 <= '0;
      end else begin
         r_a1    <= w_issue ? w_head.a1 : '0;
         r_last1 <= w_issue && w_head.last;
         r_last2 <= r_last1;
         if (w_issue) r_cnt <= w_head.last ? '0 : r_cnt + 1'b1;
         if (w_issue && w_head.last) r_len1 <= r_cnt + 1'b1;
         if (r_last1) begin
            r_cap0 <= i_pe_c0;
            r_len2 <= r_len1;
         end
         if (r_last2) begin
            r_prev0 <= r_cap0;
            r_prev1 <= i_pe_c1;
         end
      end
   end

   assign w_res_in = '{c0: r_cap0 - r_prev0, c1: i_pe_c1 - r_prev1, len: r_len2};

   pe_row_sync_fifo #(.W($bits(res_t)), .D(RES_DEPTH)) u_res_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_valid (r_last2),
      .i_data  (w_res_in),
      .o_valid (o_res_valid),
      .i_ready (i_res_ready),
      .o_data  (w_res_out),
      .o_count (w_res_count)
   );

   assign o_res_c0  = w_res_out.c0;
   assign o_res_c1  = w_res_out.c1;
   assign o_res_len = w_res_out.len;
endmodule

// File: tb/tb_pe_row_feeder.sv
// tb_pe_row_feeder: feeder driving a behavioural 1x2 PE row; scoreboard checks every tile result.
module tb_pe_row_feeder;
   import pe_row_pkg::*;
   localparam int DW = 16;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_in_valid = 1'b0, i_in_last = 1'b0, i_res_ready = 1'b1;
   logic [DW-1:0] i_in_a0 = '0, i_in_a1 = '0, i_in_b = '0;
   logic          o_in_ready, o_res_valid;
   logic [DW-1:0] o_a0, o_a1, o_b0;
   logic [AW-1:0] o_res_c0, o_res_c1;
   logic [15:0]   o_res_len;
   logic [AW-1:0] pe_c0, pe_c1;
   logic [DW-1:0] pe_b1;
   logic          rnd_bp = 1'b0, want_ready = 1'b1;
   res_t          exp_q[$];
   int            n_chk = 0, n_bad = 0;

   always #5 clk = ~clk;

   pe_row_feeder dut (
      .clk(clk), .rst(rst),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_a0(i_in_a0), .i_in_a1(i_in_a1), .i_in_b(i_in_b), .i_in_last(i_in_last),
      .o_a0(o_a0), .o_a1(o_a1), .o_b0(o_b0),
      .i_pe_c0(pe_c0), .i_pe_c1(pe_c1),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
      .o_res_c0(o_res_c0), .o_res_c1(o_res_c1), .o_res_len(o_res_len)
   );

   // Stand-in for the 1x2 PE row: b hops through a register from PE0 to PE1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pe_c0 <= '0;
         pe_c1 <= '0;
         pe_b1 <= '0;
      end else begin
         pe_c0 <= pe_c0 + AW'(o_a0) * AW'(o_b0);
         pe_b1 <= o_b0;
         pe_c1 <= pe_c1 + AW'(o_a1) * AW'(pe_b1);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic expect_res(input logic [AW-1:0] c0, input logic [AW-1:0] c1, input logic [15:0] len);
      exp_q.push_back('{c0: c0, c1: c1, len: len});
   endtask

   task automatic send(input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] b, input logic last);
      logic acc;
      i_in_valid = 1'b1;
      i_in_a0 = a0;
      i_in_a1 = a1;
      i_in_b = b;
      i_in_last = last;
      acc = 1'b0;
      for (int n = 0; n < 300 && !acc; n++) begin
         @(negedge clk);
         acc = o_in_ready;
         @(posedge clk);
      end
      #1 i_in_valid = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic cycles(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
      chk(nm, exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1 i_res_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : want_ready;
      end
   end

   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (!rst && o_res_valid && i_res_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("res_c0", o_res_c0, e.c0);
               chk("res_c1", o_res_c1, e.c1);
               chk("res_len", o_res_len, e.len);
            end
         end
      end
   end

   initial begin
      logic [AW-1:0] m0, m1;
      logic [15:0]   ml;
      logic [DW-1:0] ra0, ra1, rb;
      logic          rl;
      @(negedge clk);
      chk("rst_in_ready", o_in_ready, 0);
      chk("rst_a0", o_a0, 0);
      chk("rst_a1", o_a1, 0);
      chk("rst_b0", o_b0, 0);
      chk("rst_res_valid", o_res_valid, 0);
      chk("rst_res_c0", o_res_c0, 0);
      chk("rst_res_len", o_res_len, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", o_in_ready, 1);
      @(posedge clk);
      #1;
      send(16'd7, 16'd7, 16'd7, 1'b0);
      send(16'd7, 16'd7, 16'd7, 1'b0);
      send(16'd7, 16'd7, 16'd7, 1'b0);
      rst = 1'b1;
      #2;
      chk("mid_rst_in_ready", o_in_ready, 0);
      chk("mid_rst_a0", o_a0, 0);
      chk("mid_rst_a1", o_a1, 0);
      chk("mid_rst_b0", o_b0, 0);
      chk("mid_rst_res_valid", o_res_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_release_ready", o_in_ready, 1);
      @(posedge clk);
      #1;

      expect_res(32'd27, 32'd36, 16'd2);
      send(16'd1, 16'd2, 16'd3, 1'b0);
      send(16'd4, 16'd5, 16'd6, 1'b1);
      drain("drain_tile2");
      @(negedge clk);
      chk("idle_a0", o_a0, 0);
      chk("idle_b0", o_b0, 0);
      @(posedge clk);
      #1;

      expect_res(32'd4, 32'd4, 16'd1);
      expect_res(32'd12, 32'd4, 16'd1);
      send(16'd2, 16'd2, 16'd2, 1'b1);
      send(16'd3, 16'd1, 16'd4, 1'b1);
      drain("drain_b2b");

      want_ready = 1'b0;
      cycles(2);
      expect_res(32'd3, 32'd6, 16'd1);
      expect_res(32'd8, 32'd12, 16'd1);
      expect_res(32'd15, 32'd20, 16'd1);
      expect_res(32'd24, 32'd30, 16'd1);
      expect_res(32'd35, 32'd42, 16'd1);
      expect_res(32'd48, 32'd56, 16'd1);
      send(16'd1, 16'd2, 16'd3, 1'b1);
      send(16'd2, 16'd3, 16'd4, 1'b1);
      send(16'd3, 16'd4, 16'd5, 1'b1);
      send(16'd4, 16'd5, 16'd6, 1'b1);
      send(16'd5, 16'd6, 16'd7, 1'b1);
      send(16'd6, 16'd7, 16'd8, 1'b1);
      cycles(4);
      @(negedge clk);
      chk("full_in_ready", o_in_ready, 0);
      chk("stall_a0", o_a0, 0);
      chk("stall_a1", o_a1, 0);
      chk("stall_b0", o_b0, 0);
      chk("stall_res_valid", o_res_valid, 1);
      chk("stall_head_c0", o_res_c0, 3);
      @(posedge clk);
      #1 want_ready = 1'b1;
      drain("drain_backpressure");

      for (int i = 0; i < 4; i++) expect_res(32'hFFFE0001, 32'hFFFE0001, 16'd1);
      for (int i = 0; i < 4; i++) send(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
      drain("drain_wrap");

      rnd_bp = 1'b1;
      m0 = '0;
      m1 = '0;
      ml = '0;
      for (int i = 0; i < 30; i++) begin
         ra0 = DW'($urandom_range(0, 65535));
         ra1 = DW'($urandom_range(0, 65535));
         rb  = DW'($urandom_range(0, 65535));
         rl  = (i == 29) || ($urandom_range(0, 2) == 0);
         m0 = m0 + AW'(ra0) * AW'(rb);
         m1 = m1 + AW'(ra1) * AW'(rb);
         ml = ml + 16'd1;
         if (rl) begin
            expect_res(m0, m1, ml);
            m0 = '0;
            m1 = '0;
            ml = '0;
         end
         send(ra0, ra1, rb, rl);
         cycles($urandom_range(0, 2));
      end
      drain("drain_random");
      rnd_bp = 1'b0;
      cycles(3);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
